// File: rtl/ifid_stall_ctrl_pkg.sv
// Shared definitions for the IF/ID stall controller: controller states, per-cycle
// IF/ID action, and the NOP/HALT encodings also used by decode and ID/EX control.
package ifid_stall_ctrl_pkg;

    localparam int          IFID_DATA_W    = 16;
    localparam int          IFID_CNT_W     = 16;
    localparam logic [15:0] IFID_NOP_INSTR = 16'h0800;
    localparam logic [4:0]  IFID_HALT_OPC  = 5'b00000;

    typedef enum logic [1:0] {
        RUN    = 2'b00,
        HOLD   = 2'b01,
        HALTED = 2'b10
    } ctrlState_t;

    // What the IF/ID register does on the coming edge, resolved by priority.
    typedef enum logic [1:0] {
        ACT_LOAD   = 2'b00,
        ACT_HOLD   = 2'b01,
        ACT_BUBBLE = 2'b10,
        ACT_FLUSH  = 2'b11
    } ifidAction_t;

    function automatic logic isHaltOpc(input logic [4:0] opc, input logic [4:0] haltOpc);
        return opc == haltOpc;
    endfunction

endpackage

// File: rtl/ifid_stall_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear; clear beats increment.
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] count
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/ifid_stall_ctrl.sv
// IF/ID pipeline register owner: applies flush/stall/fetch-miss priority, drives the
// PC write enable and ID/EX bubble, freezes fetch on HALT, and counts stall cycles.
module ifid_stall_ctrl
    import ifid_stall_ctrl_pkg::*;
#(
    parameter int                DATA_W    = IFID_DATA_W,
    parameter logic [DATA_W-1:0] NOP_INSTR = DATA_W'(IFID_NOP_INSTR),
    parameter logic [4:0]        HALT_OPC  = IFID_HALT_OPC,
    parameter int                CNT_W     = IFID_CNT_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              stall,
    input  logic              flush,
    input  logic              imem_ready,
    input  logic [DATA_W-1:0] instr_in,
    input  logic [DATA_W-1:0] pcInc_in,
    input  logic              clr_cnt,
    output logic [DATA_W-1:0] instr_IFID,
    output logic [DATA_W-1:0] pcInc_IFID,
    output logic              valid_IFID,
    output logic              enPC,
    output logic              bubble_IDEX,
    output logic              halted,
    output logic [CNT_W-1:0]  stall_cycles
);

    ctrlState_t  state;
    ifidAction_t action;
    logic        fetchIsHalt;
    logic        stallCounts;

    assign fetchIsHalt = isHaltOpc(instr_in[DATA_W-1 -: 5], HALT_OPC);
    assign stallCounts = stall && (state != HALTED);

    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        action = ACT_LOAD;
        if (flush) begin
            action = ACT_FLUSH;
        end else if ((state == HALTED) || stall) begin
            action = ACT_HOLD;
        end else if (!imem_ready) begin
            action = ACT_BUBBLE;
        end
    end

    // Flush lets the external PC mux load the branch target; a fetched HALT freezes the PC.
    assign enPC        = (action == ACT_FLUSH) || ((action == ACT_LOAD) && !fetchIsHalt);
    assign bubble_IDEX = flush || stallCounts || !valid_IFID;

    // NOTE: sequential state uses non-blocking assignments so every register samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= RUN;
            instr_IFID <= NOP_INSTR;
            pcInc_IFID <= '0;
            valid_IFID <= 1'b0;
            halted     <= 1'b0;
        end else begin
            unique case (action)
                ACT_FLUSH: begin
                    // A flush in HALTED means the HALT was on the wrong path.
                    state      <= RUN;
                    instr_IFID <= NOP_INSTR;
                    valid_IFID <= 1'b0;
                    halted     <= 1'b0;
                end
                ACT_HOLD: begin
                    if (state != HALTED) begin
                        state <= HOLD;
                    end
                end
                ACT_BUBBLE: begin
                    state      <= RUN;
                    instr_IFID <= NOP_INSTR;
                    valid_IFID <= 1'b0;
                end
                ACT_LOAD: begin
                    instr_IFID <= instr_in;
                    pcInc_IFID <= pcInc_in;
                    valid_IFID <= 1'b1;
                    if (fetchIsHalt) begin
                        state  <= HALTED;
                        halted <= 1'b1;
                    end else begin
                        state <= RUN;
                    end
                end
            endcase
        end
    end

    sat_counter #(
        .CNT_W (CNT_W)
    ) u_stallCounter (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (stallCounts),
        .clr   (clr_cnt),
        .count (stall_cycles)
    );

endmodule

// File: tb/tb_ifid_stall_ctrl.sv
// Self-checking bench for ifid_stall_ctrl: a vector table driven through a scoreboard,
// then hand sequences for counter saturation/clear and reset asserted mid-HOLD.
module tb_ifid_stall_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall, flush, imem_ready, clr_cnt;
    logic [15:0] instr_in, pcInc_in;
    logic [15:0] instr_IFID, pcInc_IFID, stall_cycles;
    logic        valid_IFID, enPC, bubble_IDEX, halted;

    ifid_stall_ctrl dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .stall        (stall),
        .flush        (flush),
        .imem_ready   (imem_ready),
        .instr_in     (instr_in),
        .pcInc_in     (pcInc_in),
        .clr_cnt      (clr_cnt),
        .instr_IFID   (instr_IFID),
        .pcInc_IFID   (pcInc_IFID),
        .valid_IFID   (valid_IFID),
        .enPC         (enPC),
        .bubble_IDEX  (bubble_IDEX),
        .halted       (halted),
        .stall_cycles (stall_cycles)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        stall, flush, ready, clr;
        logic [15:0] instr, pc;
        logic        chkEn, expEn, expBub;
        logic [15:0] expI;
        logic        chkP;
        logic [15:0] expP;
        logic        expV, expH;
        logic [15:0] expC;
    } vec_t;

    vec_t vecs[16];
    vec_t sb[$];
    int   passCnt = 0;
    int   totalCnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        totalCnt++;
        if (act === exp) passCnt++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic vec_t mk(input logic st, fl, rd, cl, input logic [15:0] ins, pc,
                                input logic chkEn, expEn, expBub, input logic [15:0] expI,
                                input logic chkP, input logic [15:0] expP,
                                input logic expV, expH, input logic [15:0] expC);
        vec_t v;
        v.stall = st; v.flush = fl; v.ready = rd; v.clr = cl; v.instr = ins; v.pc = pc;
        v.chkEn = chkEn; v.expEn = expEn; v.expBub = expBub; v.expI = expI;
        v.chkP = chkP; v.expP = expP; v.expV = expV; v.expH = expH; v.expC = expC;
        return v;
    endfunction

    task automatic applyVec(input vec_t v, input int idx);
        vec_t e;
        @(negedge clk);
        stall = v.stall; flush = v.flush; imem_ready = v.ready; clr_cnt = v.clr;
        instr_in = v.instr; pcInc_in = v.pc;
        #1;
        if (v.chkEn) check($sformatf("v%0d enPC", idx), enPC, v.expEn);
        check($sformatf("v%0d bubble", idx), bubble_IDEX, v.expBub);
        sb.push_back(v);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        check($sformatf("v%0d instr", idx), instr_IFID, e.expI);
        if (e.chkP) check($sformatf("v%0d pcInc", idx), pcInc_IFID, e.expP);
        check($sformatf("v%0d valid", idx), valid_IFID, e.expV);
        check($sformatf("v%0d halted", idx), halted, e.expH);
        check($sformatf("v%0d cnt", idx), stall_cycles, e.expC);
    endtask

    initial begin
        //             st fl rd cl instr    pc        chkEn en bub expI     chkP expP     V  H  cnt
        vecs[0]  = mk(0, 0, 1, 0, 16'h4123, 16'h0002, 1, 1, 1, 16'h4123, 1, 16'h0002, 1, 0, 16'd0);
        vecs[1]  = mk(1, 0, 1, 0, 16'h5111, 16'h0004, 1, 0, 1, 16'h4123, 1, 16'h0002, 1, 0, 16'd1);
        vecs[2]  = mk(1, 0, 1, 0, 16'h5222, 16'h0006, 1, 0, 1, 16'h4123, 1, 16'h0002, 1, 0, 16'd2);
        vecs[3]  = mk(1, 0, 1, 0, 16'h5333, 16'h0008, 1, 0, 1, 16'h4123, 1, 16'h0002, 1, 0, 16'd3);
        vecs[4]  = mk(0, 0, 1, 0, 16'h5333, 16'h0008, 1, 1, 0, 16'h5333, 1, 16'h0008, 1, 0, 16'd3);
        vecs[5]  = mk(1, 1, 1, 0, 16'h6000, 16'h0100, 1, 1, 1, 16'h0800, 0, 16'h0000, 0, 0, 16'd4);
        vecs[6]  = mk(0, 0, 1, 0, 16'h7001, 16'h000A, 1, 1, 1, 16'h7001, 1, 16'h000A, 1, 0, 16'd4);
        vecs[7]  = mk(0, 0, 0, 0, 16'h7002, 16'h000C, 1, 0, 0, 16'h0800, 0, 16'h0000, 0, 0, 16'd4);
        vecs[8]  = mk(0, 0, 0, 0, 16'h7003, 16'h000C, 1, 0, 1, 16'h0800, 0, 16'h0000, 0, 0, 16'd4);
        vecs[9]  = mk(0, 0, 1, 0, 16'h0000, 16'h000C, 1, 0, 1, 16'h0000, 1, 16'h000C, 1, 1, 16'd4);
        vecs[10] = mk(1, 0, 1, 0, 16'h4444, 16'h000E, 1, 0, 0, 16'h0000, 1, 16'h000C, 1, 1, 16'd4);
        vecs[11] = mk(0, 0, 1, 0, 16'h4445, 16'h000E, 1, 0, 0, 16'h0000, 1, 16'h000C, 1, 1, 16'd4);
        vecs[12] = mk(1, 0, 1, 0, 16'h4446, 16'h000E, 1, 0, 0, 16'h0000, 1, 16'h000C, 1, 1, 16'd4);
        vecs[13] = mk(0, 1, 1, 0, 16'h4447, 16'h000E, 0, 0, 1, 16'h0800, 0, 16'h0000, 0, 0, 16'd4);
        vecs[14] = mk(0, 0, 1, 0, 16'h4123, 16'h000E, 1, 1, 1, 16'h4123, 1, 16'h000E, 1, 0, 16'd4);
        vecs[15] = mk(0, 0, 1, 1, 16'h4124, 16'h0010, 1, 1, 0, 16'h4124, 1, 16'h0010, 1, 0, 16'd0);

        rst_n = 1'b0; stall = 1'b0; flush = 1'b0; imem_ready = 1'b0; clr_cnt = 1'b0;
        instr_in = 16'h0000; pcInc_in = 16'h0000;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("reset instr", instr_IFID, 16'h0800);
        check("reset pcInc", pcInc_IFID, 16'h0000);
        check("reset valid", valid_IFID, 1'b0);
        check("reset halted", halted, 1'b0);
        check("reset cnt", stall_cycles, 16'h0000);
        check("reset bubble", bubble_IDEX, 1'b1);

        for (int i = 0; i < 16; i++) applyVec(vecs[i], i);

        // Continuous stall drives the counter to saturation.
        @(negedge clk);
        stall = 1'b1; clr_cnt = 1'b0; imem_ready = 1'b1; instr_in = 16'h4999;
        repeat (65535) @(posedge clk);
        #1;
        check("sat reach", stall_cycles, 16'hFFFF);
        @(posedge clk);
        #1;
        check("sat hold", stall_cycles, 16'hFFFF);
        check("sat instr held", instr_IFID, 16'h4124);
        @(negedge clk);
        clr_cnt = 1'b1;
        @(posedge clk);
        #1;
        check("clr over inc", stall_cycles, 16'h0000);

        // Reset asserted in HOLD clears outputs without a clock edge.
        @(negedge clk);
        clr_cnt = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("hold cnt", stall_cycles, 16'd2);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("async rst instr", instr_IFID, 16'h0800);
        check("async rst valid", valid_IFID, 1'b0);
        check("async rst cnt", stall_cycles, 16'h0000);
        check("async rst halted", halted, 1'b0);
        @(negedge clk);
        stall = 1'b0; imem_ready = 1'b1; instr_in = 16'h4555; pcInc_in = 16'h0020;
        rst_n = 1'b1;
        #1;
        check("post rst enPC", enPC, 1'b1);
        @(posedge clk);
        #1;
        check("post rst instr", instr_IFID, 16'h4555);
        check("post rst valid", valid_IFID, 1'b1);

        $display("%0d/%0d checks passed", passCnt, totalCnt);
        $finish;
    end

endmodule
